// File: rtl/packet_router_vc.sv
// Wormhole router stage: steers each packet, head to tail, to the local FIFO,
// the forward FIFO, or both, and counts stray or protocol-error flits.

module packet_router_vc_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             full_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];
    assign pop     = valid_o && ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module packet_router_vc #(
    parameter int unsigned                 FLIT_WIDTH     = 64,
    parameter int unsigned                 NODE_ID_WIDTH  = 8,
    parameter logic [NODE_ID_WIDTH-1:0]    NODE_ID        = '0,
    parameter logic [NODE_ID_WIDTH-1:0]    BCAST_ID       = '1,
    parameter int unsigned                 FIFO_DEPTH     = 4,
    parameter int unsigned                 DROP_CNT_WIDTH = 8
) (
    input  logic                      nocclk,
    input  logic                      rst_n,
    input  logic [FLIT_WIDTH-1:0]     in_flit,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [FLIT_WIDTH-1:0]     local_flit,
    output logic                      local_valid,
    input  logic                      local_ready,
    output logic [FLIT_WIDTH-1:0]     fwd_flit,
    output logic                      fwd_valid,
    input  logic                      fwd_ready,
    output logic                      busy,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOCAL, ST_FWD, ST_BCAST} state_e;
    typedef enum logic [1:0] {FT_HEAD, FT_BODY, FT_TAIL, FT_SINGLE} flit_type_e;

    state_e                    state_q, state_d;
    logic                      busy_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    flit_type_e                ftype;
    logic [NODE_ID_WIDTH-1:0]  dest;
    logic                      accept;
    logic                      push_local, push_fwd, drop;
    logic                      local_full, fwd_full;

    assign ftype = flit_type_e'(in_flit[FLIT_WIDTH-1 -: 2]);
    assign dest  = in_flit[FLIT_WIDTH-3 -: NODE_ID_WIDTH];

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (ftype == FT_HEAD) begin
                    if (dest == NODE_ID) begin
                        state_d = ST_LOCAL;
                    end else if (dest == BCAST_ID) begin
                        state_d = ST_BCAST;
                    end else begin
                        state_d = ST_FWD;
                    end
                end
            end else if (ftype != FT_BODY) begin
                // TAIL closes the packet; a HEAD/SINGLE here closes it as an error
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        push_local = 1'b0;
        push_fwd   = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            ST_IDLE:  in_ready = !local_full && !fwd_full;
            ST_LOCAL: in_ready = !local_full;
            ST_FWD:   in_ready = !fwd_full;
            ST_BCAST: in_ready = !local_full && !fwd_full;
        endcase
        accept = in_valid && in_ready;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ftype == FT_HEAD || ftype == FT_SINGLE) begin
                        if (dest == NODE_ID) begin
                            push_local = 1'b1;
                        end else if (dest == BCAST_ID) begin
                            push_local = 1'b1;
                            push_fwd   = 1'b1;
                        end else begin
                            push_fwd = 1'b1;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
                ST_LOCAL: push_local = 1'b1;
                ST_FWD:   push_fwd   = 1'b1;
                ST_BCAST: begin
                    push_local = 1'b1;
                    push_fwd   = 1'b1;
                end
            endcase
            if (state_q != ST_IDLE && (ftype == FT_HEAD || ftype == FT_SINGLE)) begin
                drop = 1'b1;
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (drop && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
    end

    packet_router_vc_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_local_fifo (
        .clk     (nocclk),
        .rst_n   (rst_n),
        .push_i  (push_local),
        .din_i   (in_flit),
        .ready_i (local_ready),
        .dout_o  (local_flit),
        .valid_o (local_valid),
        .full_o  (local_full)
    );

    packet_router_vc_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fwd_fifo (
        .clk     (nocclk),
        .rst_n   (rst_n),
        .push_i  (push_fwd),
        .din_i   (in_flit),
        .ready_i (fwd_ready),
        .dout_o  (fwd_flit),
        .valid_o (fwd_valid),
        .full_o  (fwd_full)
    );

    assign busy       = busy_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_packet_router_vc.sv
// Directed bench for packet_router_vc: per-cycle vector table plus hand-written
// backpressure and mid-packet reset sequences. A second instance checks drop saturation.

module tb_packet_router_vc;
    logic        nocclk = 1'b0;
    logic        rst_n;
    logic [63:0] in_flit;
    logic        in_valid;
    logic        in_ready, in_ready_s;
    logic [63:0] local_flit, local_flit_s;
    logic        local_valid, local_valid_s;
    logic        local_ready;
    logic [63:0] fwd_flit, fwd_flit_s;
    logic        fwd_valid, fwd_valid_s;
    logic        fwd_ready;
    logic        busy, busy_s;
    logic [7:0]  drop_count;
    logic [1:0]  drop_count_s;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic        mon_en = 1'b0;
    logic [63:0] fwd_q[$];

    always #5 nocclk = ~nocclk;

    packet_router_vc #(
        .FLIT_WIDTH(64), .NODE_ID_WIDTH(8), .NODE_ID(8'd3), .BCAST_ID(8'hFF),
        .FIFO_DEPTH(4), .DROP_CNT_WIDTH(8)
    ) dut (
        .nocclk(nocclk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(in_ready), .local_flit(local_flit), .local_valid(local_valid),
        .local_ready(local_ready), .fwd_flit(fwd_flit), .fwd_valid(fwd_valid),
        .fwd_ready(fwd_ready), .busy(busy), .drop_count(drop_count)
    );

    packet_router_vc #(
        .FLIT_WIDTH(64), .NODE_ID_WIDTH(8), .NODE_ID(8'd3), .BCAST_ID(8'hFF),
        .FIFO_DEPTH(4), .DROP_CNT_WIDTH(2)
    ) dut_sat (
        .nocclk(nocclk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(in_ready_s), .local_flit(local_flit_s), .local_valid(local_valid_s),
        .local_ready(local_ready), .fwd_flit(fwd_flit_s), .fwd_valid(fwd_valid_s),
        .fwd_ready(fwd_ready), .busy(busy_s), .drop_count(drop_count_s)
    );

    // Records forward pops between the input drive and the next rising edge.
    always @(negedge nocclk) begin
        #2;
        if (mon_en && fwd_valid && fwd_ready) fwd_q.push_back(fwd_flit);
    end

    typedef struct packed {
        logic [63:0] flit;
        logic        valid;
        logic        lr;
        logic        fr;
        logic        e_rdy;
        logic        e_lv;
        logic [63:0] e_lf;
        logic        e_fv;
        logic [63:0] e_ff;
        logic        e_busy;
        logic [7:0]  e_drop;
        logic [1:0]  e_drop_s;
    } vec_t;

    localparam int NV = 16;
    vec_t vec[NV];

    function automatic logic [63:0] mkf(input logic [1:0] t, input logic [7:0] d, input logic [53:0] p);
        return {t, d, p};
    endfunction

    function automatic vec_t mkv(input logic [63:0] f, input logic v, input logic lr, input logic fr,
                                 input logic rdy, input logic lv, input logic [63:0] lf,
                                 input logic fv, input logic [63:0] ff, input logic b,
                                 input logic [7:0] d, input logic [1:0] ds);
        vec_t r;
        r.flit = f; r.valid = v; r.lr = lr; r.fr = fr; r.e_rdy = rdy;
        r.e_lv = lv; r.e_lf = lf; r.e_fv = fv; r.e_ff = ff;
        r.e_busy = b; r.e_drop = d; r.e_drop_s = ds;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_flit(input logic [63:0] f, input string nm);
        int unsigned waited;
        waited = 0;
        @(negedge nocclk);
        in_flit  = f;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 40) begin
            @(negedge nocclk);
            #1;
            waited++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL %s: in_ready still 0 after %0d cycles, expected 1", nm, waited);
            in_valid = 1'b0;
        end else begin
            @(posedge nocclk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] h1, b1, b2, t1, s1, x1, x2, x3, x4, x5, h2, h3;
        logic [63:0] exp_fwd[7];
        logic [63:0] rh, rb;

        h1 = mkf(2'b00, 8'd3,   54'h101);
        b1 = mkf(2'b01, 8'd0,   54'h102);
        b2 = mkf(2'b01, 8'd0,   54'h103);
        t1 = mkf(2'b10, 8'd0,   54'h104);
        s1 = mkf(2'b11, 8'hFF,  54'h2AA);
        x1 = mkf(2'b01, 8'd3,   54'h301);
        x2 = mkf(2'b10, 8'd3,   54'h302);
        x3 = mkf(2'b01, 8'd7,   54'h303);
        x4 = mkf(2'b10, 8'd7,   54'h304);
        x5 = mkf(2'b01, 8'hFF,  54'h305);
        h2 = mkf(2'b00, 8'd3,   54'h401);
        h3 = mkf(2'b00, 8'd7,   54'h402);

        //          flit v  lr fr rdy lv lf  fv ff  busy drop ds
        vec[0]  = mkv(h1, 1, 1, 1, 1, 1, h1, 0, 0, 1, 0, 0);
        vec[1]  = mkv(b1, 1, 1, 1, 1, 1, b1, 0, 0, 1, 0, 0);
        vec[2]  = mkv(b2, 1, 1, 1, 1, 1, b2, 0, 0, 1, 0, 0);
        vec[3]  = mkv(t1, 1, 1, 1, 1, 1, t1, 0, 0, 0, 0, 0);
        vec[4]  = mkv(0,  0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        vec[5]  = mkv(s1, 1, 0, 0, 1, 1, s1, 1, s1, 0, 0, 0);
        vec[6]  = mkv(0,  0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        vec[7]  = mkv(x1, 1, 1, 1, 1, 0, 0,  0, 0, 0, 1, 1);
        vec[8]  = mkv(x2, 1, 1, 1, 1, 0, 0,  0, 0, 0, 2, 2);
        vec[9]  = mkv(x3, 1, 1, 1, 1, 0, 0,  0, 0, 0, 3, 3);
        vec[10] = mkv(x4, 1, 1, 1, 1, 0, 0,  0, 0, 0, 4, 3);
        vec[11] = mkv(x5, 1, 1, 1, 1, 0, 0,  0, 0, 0, 5, 3);
        vec[12] = mkv(h2, 1, 0, 1, 1, 1, h2, 0, 0, 1, 5, 3);
        vec[13] = mkv(h3, 1, 0, 1, 1, 1, h2, 0, 0, 0, 6, 3);
        vec[14] = mkv(0,  0, 1, 1, 1, 1, h3, 0, 0, 0, 6, 3);
        vec[15] = mkv(0,  0, 1, 1, 1, 0, 0,  0, 0, 0, 6, 3);

        rst_n = 1'b0; in_flit = '0; in_valid = 1'b0; local_ready = 1'b1; fwd_ready = 1'b1;
        repeat (2) @(negedge nocclk);
        #1;
        check("rst_local_valid", local_valid, 0);
        check("rst_local_flit",  local_flit, 0);
        check("rst_fwd_valid",   fwd_valid, 0);
        check("rst_fwd_flit",    fwd_flit, 0);
        check("rst_busy",        busy, 0);
        check("rst_drop",        drop_count, 0);
        check("rst_in_ready",    in_ready, 1);
        @(negedge nocclk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge nocclk);
            in_flit = vec[i].flit; in_valid = vec[i].valid;
            local_ready = vec[i].lr; fwd_ready = vec[i].fr;
            #1;
            check($sformatf("v%0d_in_ready", i), in_ready, vec[i].e_rdy);
            @(posedge nocclk);
            #1;
            check($sformatf("v%0d_local_valid", i), local_valid, vec[i].e_lv);
            if (vec[i].e_lv) check($sformatf("v%0d_local_flit", i), local_flit, vec[i].e_lf);
            check($sformatf("v%0d_fwd_valid", i), fwd_valid, vec[i].e_fv);
            if (vec[i].e_fv) check($sformatf("v%0d_fwd_flit", i), fwd_flit, vec[i].e_ff);
            check($sformatf("v%0d_busy", i), busy, vec[i].e_busy);
            check($sformatf("v%0d_drop", i), drop_count, vec[i].e_drop);
            check($sformatf("v%0d_drop_sat", i), drop_count_s, vec[i].e_drop_s);
        end

        // Forward backpressure: HEAD(dest 7) + 5 BODY + TAIL with fwd_ready low.
        @(negedge nocclk);
        in_valid = 1'b0; local_ready = 1'b1; fwd_ready = 1'b0;
        exp_fwd[0] = mkf(2'b00, 8'd7, 54'h500);
        for (int i = 1; i < 6; i++) exp_fwd[i] = mkf(2'b01, 8'd0, 54'h500 + 54'(i));
        exp_fwd[6] = mkf(2'b10, 8'd0, 54'h5FF);
        fwd_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) push_flit(exp_fwd[i], $sformatf("bp_accept%0d", i));
        @(negedge nocclk);
        in_flit = exp_fwd[4]; in_valid = 1'b1;
        #1;
        check("bp_stall_in_ready", in_ready, 0);
        check("bp_fwd_valid", fwd_valid, 1);
        check("bp_fwd_head", fwd_flit, exp_fwd[0]);
        check("bp_busy", busy, 1);
        check("bp_local_valid", local_valid, 0);
        fwd_ready = 1'b1;
        for (int i = 4; i < 7; i++) push_flit(exp_fwd[i], $sformatf("bp_accept%0d", i));
        check("bp_busy_after_tail", busy, 0);
        repeat (8) @(negedge nocclk);
        mon_en = 1'b0;
        check("bp_pop_count", 64'(fwd_q.size()), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < fwd_q.size()) check($sformatf("bp_order%0d", i), fwd_q[i], exp_fwd[i]);
        end
        check("bp_drop", drop_count, 6);

        // Asynchronous reset with three flits queued in the local FIFO.
        local_ready = 1'b0;
        push_flit(mkf(2'b00, 8'd3, 54'h601), "rst_seq_h");
        push_flit(mkf(2'b01, 8'd0, 54'h602), "rst_seq_b0");
        push_flit(mkf(2'b01, 8'd0, 54'h603), "rst_seq_b1");
        check("pre_rst_local_valid", local_valid, 1);
        check("pre_rst_busy", busy, 1);
        @(negedge nocclk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_local_valid", local_valid, 0);
        check("async_rst_local_flit", local_flit, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_drop", drop_count, 0);
        @(negedge nocclk);
        rst_n = 1'b1;
        local_ready = 1'b1;
        push_flit(mkf(2'b01, 8'd0, 54'h604), "post_rst_body");
        push_flit(mkf(2'b10, 8'd0, 54'h605), "post_rst_tail");
        check("post_rst_drop", drop_count, 2);
        check("post_rst_drop_sat", drop_count_s, 2);
        check("post_rst_no_push", local_valid, 0);
        rh = mkf(2'b00, 8'd3, 54'h700);
        rb = mkf(2'b10, 8'd0, 54'h701);
        push_flit(rh, "new_head");
        check("new_head_local_valid", local_valid, 1);
        check("new_head_local_flit", local_flit, rh);
        check("new_head_busy", busy, 1);
        check("new_head_fwd_valid", fwd_valid, 0);
        push_flit(rb, "new_tail");
        check("new_tail_local_flit", local_flit, rb);
        check("new_tail_busy", busy, 0);
        check("new_tail_drop", drop_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
